aud_recorder: RTL and testbench

AUD_RECORDER -- requirements
Module: aud_recorder

---
 rtl/aud_pkg.sv | 16 +
 rtl/aud_recorder_i2s_rx_shift.sv | 36 +++
 rtl/aud_recorder.sv | 117 +++++++++++
 tb/tb_aud_recorder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared audio definitions used by both the recorder and the player.
// Holds the controller state encoding and the default sample/address widths.
package aud_pkg;

  localparam int AUD_DATA_W = 16;
  localparam int AUD_ADDR_W = 20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SHIFT = 3'd2,
    S_STORE = 3'd3,
    S_PAUSE = 3'd4
  } aud_state_t;

endpackage

// File: rtl/aud_recorder_i2s_rx_shift.sv
// Serial-to-parallel capture of one I2S channel word, MSB first.
// o_word combines the stored bits with the bit being sampled, so it is complete when o_done fires.
module i2s_rx_shift #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_word,
  output logic              o_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-2:0] partial_reg;

  assign o_word = {partial_reg, i_bit};
  assign o_done = i_en && (cnt_reg == CNT_W'(DATA_W - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg     <= '0;
      partial_reg <= '0;
    end else if (i_clr) begin
      cnt_reg     <= '0;
      partial_reg <= '0;
    end else if (i_en) begin
      cnt_reg     <= cnt_reg + CNT_W'(1);
      partial_reg <= o_word[DATA_W-2:0];
    end
  end

endmodule

// File: rtl/aud_recorder.sv
// I2S audio recorder: captures one channel from the codec and emits SRAM write strobes
// at consecutive word addresses, with start/pause/stop control and a full flag.
module aud_recorder
  import aud_pkg::*;
#(
  parameter int              DATA_W      = AUD_DATA_W,
  parameter int              ADDR_W      = AUD_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR  = ADDR_W'(20'hFFFFF),
  parameter bit              CHANNEL_SEL = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_busy
);

  aud_state_t        state_reg, state_next;
  logic              lrc_q;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              full_reg, full_next;
  logic              frame_start;
  logic              shift_en;
  logic [DATA_W-1:0] rx_word;
  logic              rx_done;

  assign frame_start = (i_lrc != lrc_q) && (i_lrc == CHANNEL_SEL);
  assign shift_en    = (state_reg == S_SHIFT);

  // Counter and partial word are cleared whenever not shifting, so any abort discards them.
  i2s_rx_shift #(.DATA_W(DATA_W)) u_rx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (!shift_en),
    .i_en    (shift_en),
    .i_bit   (i_data),
    .o_word  (rx_word),
    .o_done  (rx_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= S_IDLE;
      lrc_q     <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      full_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      lrc_q     <= i_lrc;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      full_reg  <= full_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    full_next  = full_reg;
    case (state_reg)
      S_IDLE: begin
        if (!i_stop && i_start) begin
          addr_next  = '0;
          full_next  = 1'b0;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_stop)           state_next = S_IDLE;
        else if (i_pause)     state_next = S_PAUSE;
        else if (frame_start) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (i_stop)       state_next = S_IDLE;
        else if (i_pause) state_next = S_PAUSE;
        else if (rx_done) begin
          data_next  = rx_word;
          state_next = S_STORE;
        end
      end
      S_STORE: begin
        // The strobe always completes; control pulses only steer where we go afterwards.
        if (addr_reg == MAX_ADDR) begin
          full_next  = 1'b1;
          state_next = S_IDLE;
        end else begin
          addr_next = addr_reg + ADDR_W'(1);
          if (i_stop)       state_next = S_IDLE;
          else if (i_pause) state_next = S_PAUSE;
          else              state_next = S_WAIT;
        end
      end
      S_PAUSE: begin
        if (i_stop)       state_next = S_IDLE;
        else if (i_start) state_next = S_WAIT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign o_address = addr_reg;
  assign o_data    = data_reg;
  assign o_full    = full_reg;
  assign o_valid   = (state_reg == S_STORE);
  assign o_busy    = (state_reg == S_WAIT) || (state_reg == S_SHIFT) || (state_reg == S_STORE);

endmodule

// File: tb/tb_aud_recorder.sv
// Scoreboard bench for aud_recorder: expected strobes are queued as frames are driven
// and matched (data, address, cycle) when o_valid appears.
module tb_aud_recorder;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_lrc = 1'b1;
  logic        i_data = 1'b0;
  logic        i_start = 1'b0;
  logic        i_pause = 1'b0;
  logic        i_stop = 1'b0;
  logic [19:0] o_address;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_full;
  logic        o_busy;

  typedef struct {
    logic [15:0] data;
    logic [19:0] addr;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   nstrobe = 0;

  aud_recorder #(
    .DATA_W(16), .ADDR_W(20), .MAX_ADDR(20'd3), .CHANNEL_SEL(1'b0)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lrc(i_lrc), .i_data(i_data),
    .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
    .o_address(o_address), .o_data(o_data), .o_valid(o_valid),
    .o_full(o_full), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      nstrobe++;
      $display("strobe cyc=%0d addr=%0h data=%04h", cyc, o_address, o_data);
      if (sb.size() == 0) begin
        chk("spurious_strobe", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("st_data", 32'(o_data), 32'(e.data));
        chk("st_addr", 32'(o_address), 32'(e.addr));
        chk("st_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_pause = 1'b0;
    i_stop  = 1'b0;
  endtask

  // k = {stop, pause, start}
  task automatic pulse(input logic [2:0] k);
    step();
    {i_stop, i_pause, i_start} = k;
    step();
  endtask

  // One left half (frame start, 16 data bits, padding) then a right half of noise.
  // pk = {reset, stop, pause, start} applied in the cycle carrying bit pbit.
  task automatic frame(input logic [15:0] d, input bit store, input logic [19:0] addr,
                       input int pbit, input logic [3:0] pk);
    int t0;
    step();
    i_lrc  = 1'b0;
    i_data = 1'($urandom);
    t0 = cyc;
    if (store) sb.push_back('{data: d, addr: addr, cyc: t0 + 17});
    for (int k = 0; k < 16; k++) begin
      step();
      i_data = d[15-k];
      if (k == pbit) begin
        {i_stop, i_pause, i_start} = pk[2:0];
        if (pk[3]) begin
          #2 i_rst_n = 1'b0;
          #1;
          chk("rst_addr", 32'(o_address), 32'd0);
          chk("rst_data", 32'(o_data), 32'd0);
          chk("rst_valid", 32'(o_valid), 32'd0);
          chk("rst_full", 32'(o_full), 32'd0);
          chk("rst_busy", 32'(o_busy), 32'd0);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      step();
      i_data  = 1'($urandom);
      i_rst_n = 1'b1;
    end
    for (int k = 0; k < 20; k++) begin
      step();
      i_lrc  = 1'b1;
      i_data = 1'($urandom);
    end
  endtask

  initial begin
    #2 i_rst_n = 1'b0;
    repeat (3) step();
    chk("init_addr", 32'(o_address), 32'd0);
    chk("init_data", 32'(o_data), 32'd0);
    chk("init_valid", 32'(o_valid), 32'd0);
    chk("init_full", 32'(o_full), 32'd0);
    chk("init_busy", 32'(o_busy), 32'd0);
    i_rst_n = 1'b1;
    repeat (3) step();

    pulse(3'b001);
    chk("busy_after_start", 32'(o_busy), 32'd1);
    frame(16'hA5C3, 1'b1, 20'd0, -1, 4'b0000);
    chk("addr_after_first", 32'(o_address), 32'd1);

    pulse(3'b100);
    chk("stop_addr_hold", 32'(o_address), 32'd1);
    chk("stop_busy", 32'(o_busy), 32'd0);
    pulse(3'b001);
    chk("restart_addr", 32'(o_address), 32'd0);
    frame(16'h0001, 1'b1, 20'd0, -1, 4'b0000);
    frame(16'h8000, 1'b1, 20'd1, -1, 4'b0000);
    frame(16'hFFFF, 1'b1, 20'd2, -1, 4'b0000);
    chk("addr_after_three", 32'(o_address), 32'd3);
    frame(16'h1234, 1'b1, 20'd3, -1, 4'b0000);
    chk("full_set", 32'(o_full), 32'd1);
    chk("full_idle", 32'(o_busy), 32'd0);
    chk("full_addr", 32'(o_address), 32'd3);
    frame(16'h5555, 1'b0, 20'd0, -1, 4'b0000);

    pulse(3'b001);
    chk("full_cleared", 32'(o_full), 32'd0);
    chk("addr_cleared", 32'(o_address), 32'd0);
    frame(16'h0F0F, 1'b0, 20'd0, 8, 4'b0010);
    chk("pause_addr", 32'(o_address), 32'd0);
    chk("pause_busy", 32'(o_busy), 32'd0);
    pulse(3'b001);
    frame(16'h3C3C, 1'b1, 20'd0, -1, 4'b0000);
    chk("resume_addr", 32'(o_address), 32'd1);

    frame(16'h7777, 1'b0, 20'd0, 5, 4'b0110);
    chk("stoppause_busy", 32'(o_busy), 32'd0);
    chk("stoppause_addr", 32'(o_address), 32'd1);
    pulse(3'b001);
    chk("start_clears", 32'(o_address), 32'd0);
    frame(16'h1357, 1'b1, 20'd0, -1, 4'b0000);
    chk("addr_pre_reset", 32'(o_address), 32'd1);

    frame(16'h2468, 1'b0, 20'd0, 10, 4'b1000);
    frame(16'h9999, 1'b0, 20'd0, -1, 4'b0000);
    chk("post_reset_idle", 32'(o_busy), 32'd0);
    pulse(3'b001);
    frame(16'hCAFE, 1'b1, 20'd0, -1, 4'b0000);
    chk("final_addr", 32'(o_address), 32'd1);

    repeat (5) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("strobe_cnt", 32'(nstrobe), 32'd8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
